// File: rtl/function_reader.sv
// Streams 1..4 function vectors from the generator ROM as LM-bit chunks,
// MSB first, over a valid/ready port with per-vector and end-of-run markers.
module function_reader #(
    parameter int K_N = 256,
    parameter int LM  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     start_adrs,
    input  logic [1:0]     num_vec,
    output logic [1:0]     adrs,
    input  logic [K_N-1:0] f_in,
    output logic [LM-1:0]  out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic           out_end,
    output logic           busy,
    output logic           done
);

    localparam int NCH = K_N / LM;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     rem;
    logic [CW-1:0]  cnt;
    logic [K_N-1:0] sreg;
    logic           go;
    logic           xfer;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        xfer      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    go        = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                if (out_ready) begin
                    xfer = 1'b1;
                    if (out_last) begin
                        state_nxt = (rem == 2'd0) ? IDLE : FETCH;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign out_valid = (state == STREAM);
    assign out_data  = sreg[K_N-1 -: LM];
    assign out_last  = out_valid && (cnt == LAST_CH);
    assign out_end   = out_last && (rem == 2'd0);
    assign busy      = (state != IDLE);

    // adrs stays put from FETCH until the last chunk of its vector leaves
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adrs <= 2'd0;
            rem  <= 2'd0;
            cnt  <= '0;
            sreg <= '0;
            done <= 1'b0;
        end else begin
            done <= xfer && out_end;
            if (go) begin
                adrs <= start_adrs;
                rem  <= num_vec;
            end
            if (state == FETCH) begin
                sreg <= f_in;
                cnt  <= '0;
            end
            if (xfer) begin
                sreg <= sreg << LM;
                cnt  <= cnt + 1'b1;
                if (out_last && (rem != 2'd0)) begin
                    adrs <= adrs + 2'd1;
                    rem  <= rem - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_function_reader.sv
// Bench for function_reader: ROM model, chunk scoreboard, run table
// and hand-written restart / mid-run reset sequences.
module tb_function_reader;

    localparam int K_N = 256;
    localparam int LM  = 16;
    localparam int NCH = K_N / LM;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [1:0]     start_adrs;
    logic [1:0]     num_vec;
    logic [1:0]     adrs;
    logic [K_N-1:0] f_in;
    logic [LM-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           out_end;
    logic           busy;
    logic           done;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        eend;
        logic [1:0]  adr;
    } exp_t;

    typedef struct {
        logic [1:0] sa;
        logic [1:0] nv;
        bit         rnd;
        int         exp_last;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[5];
    logic [15:0] rom[4][16];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int first_idx, last_idx, done_idx;
    int n_xfer, n_last, n_end, n_done;
    bit rnd_mode = 1'b0;
    bit pend_done = 1'b0;
    bit prev_stall = 1'b0;
    logic [LM-1:0] hold_data;
    logic hold_last, hold_end;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        f_in = '0;
        for (int i = 0; i < NCH; i++) begin
            f_in[K_N-1-LM*i -: LM] = rom[adrs][i];
        end
    end

    function_reader #(.K_N(K_N), .LM(LM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_adrs(start_adrs),
        .num_vec(num_vec),
        .adrs(adrs),
        .f_in(f_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .out_end(out_end),
        .busy(busy),
        .done(done)
    );

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        bit   nxt;
        exp_t e;
        nxt = 1'b0;
        if (pend_done || done)
            chk(done == pend_done, "done_pulse", 64'(done), 64'(pend_done));
        if (done) begin
            n_done++;
            done_idx = cyc - t0;
        end
        if (prev_stall)
            chk(out_valid && out_data == hold_data && out_last == hold_last
                && out_end == hold_end, "stall_hold",
                {out_valid, out_data, out_last, out_end},
                {1'b1, hold_data, hold_last, hold_end});
        prev_stall = 1'b0;
        if (rst_n && out_valid && first_idx < 0)
            first_idx = cyc - t0;
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk(1'b0, "unexpected_chunk", 64'(out_data), 64'(0));
            end else begin
                e = sbq.pop_front();
                chk({out_data, out_last, out_end, adrs} == e, "chunk",
                    64'({out_data, out_last, out_end, adrs}), 64'(e));
            end
            last_idx = cyc - t0;
            n_xfer++;
            if (out_last) n_last++;
            if (out_end) begin
                n_end++;
                nxt = 1'b1;
            end
        end
        if (rst_n && out_valid && !out_ready) begin
            prev_stall = 1'b1;
            hold_data  = out_data;
            hold_last  = out_last;
            hold_end   = out_end;
        end
        pend_done = nxt;
    end

    task automatic clear_stats();
        first_idx = -1;
        last_idx  = -1;
        done_idx  = -1;
        n_xfer    = 0;
        n_last    = 0;
        n_end     = 0;
        n_done    = 0;
    endtask

    task automatic start_run(input logic [1:0] sa, input logic [1:0] nv);
        exp_t       e;
        logic [1:0] a;
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_adrs = sa;
        num_vec    = nv;
        t0         = cyc;
        for (int v = 0; v <= int'(nv); v++) begin
            a = sa + 2'(v);
            for (int i = 0; i < NCH; i++) begin
                e.data = rom[a][i];
                e.last = (i == NCH - 1);
                e.eend = (i == NCH - 1) && (v == int'(nv));
                e.adr  = a;
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk(busy && !out_valid, "fetch_state", 64'({busy, out_valid}), 64'(2));
        chk(adrs == sa, "adrs_latched", 64'(adrs), 64'(sa));
    endtask

    task automatic wait_xfers(input int n);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (n_xfer >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk(ok, "xfer_timeout", 64'(n_xfer), 64'(n));
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk);
            #1;
            if (n_done > 0 && sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(ok, "run_timeout", 64'(sbq.size()), 64'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input logic [1:0] nv, input int exp_last);
        chk(first_idx == 2, "first_valid_cycle", 64'(first_idx), 64'(2));
        chk(n_xfer == NCH * (int'(nv) + 1), "xfer_count",
            64'(n_xfer), 64'(NCH * (int'(nv) + 1)));
        chk(n_last == int'(nv) + 1, "last_count", 64'(n_last), 64'(nv + 1));
        chk(n_end == 1, "end_count", 64'(n_end), 64'(1));
        chk(n_done == 1, "done_count", 64'(n_done), 64'(1));
        chk(done_idx == last_idx + 1, "done_cycle",
            64'(done_idx), 64'(last_idx + 1));
        if (exp_last >= 0)
            chk(last_idx == exp_last, "last_xfer_cycle",
                64'(last_idx), 64'(exp_last));
        chk(!busy, "idle_after_run", 64'(busy), 64'(0));
    endtask

    task automatic do_run(input vec_t t);
        rnd_mode = t.rnd;
        clear_stats();
        start_run(t.sa, t.nv);
        wait_done();
        rnd_mode = 1'b0;
        check_run(t.nv, t.exp_last);
    endtask

    task automatic chk_zero(input string nm);
        chk({adrs, out_data, out_valid, out_last, out_end, busy, done} == '0,
            nm, 64'({adrs, out_data, out_valid, out_last, out_end, busy, done}),
            64'(0));
    endtask

    initial begin
        rom[0] = '{16'hA46E, 16'h4D42, 16'h9C17, 16'h3B80, 16'hE2D5, 16'h1F6A,
                   16'h78C3, 16'hD094, 16'h26BF, 16'h8A51, 16'hF30C, 16'h5D7E,
                   16'h0BA9, 16'hC648, 16'h6E12, 16'h53E4};
        rom[1] = '{16'hCDE5, 16'h07D9, 16'hB3A6, 16'h4F21, 16'h98EC, 16'h2A57,
                   16'hE6B0, 16'h71C8, 16'h0D3F, 16'hA9E2, 16'h5C64, 16'hF71B,
                   16'h3480, 16'h8BDD, 16'h16F5, 16'h7B32};
        rom[2] = '{16'h3C91, 16'hE40F, 16'h7A2D, 16'h15B8, 16'hC9E3, 16'h6F54,
                   16'hA207, 16'h08CA, 16'hDB6E, 16'h4391, 16'h9F25, 16'h27FC,
                   16'h8E4B, 16'h51A0, 16'hF6D7, 16'hBD19};
        rom[3] = '{16'hA03B, 16'h62F4, 16'h1DC7, 16'h94A8, 16'hF05E, 16'h3B29,
                   16'hC781, 16'h5E6D, 16'h0A93, 16'hE7B2, 16'h4C1F, 16'h89D6,
                   16'h2F40, 16'hB365, 16'h764C, 16'hEFA8};

        tbl[0] = '{sa: 2'd0, nv: 2'd0, rnd: 1'b0, exp_last: 17};
        tbl[1] = '{sa: 2'd3, nv: 2'd1, rnd: 1'b0, exp_last: 34};
        tbl[2] = '{sa: 2'd1, nv: 2'd0, rnd: 1'b1, exp_last: -1};
        tbl[3] = '{sa: 2'd0, nv: 2'd3, rnd: 1'b0, exp_last: 68};
        tbl[4] = '{sa: 2'd2, nv: 2'd2, rnd: 1'b1, exp_last: -1};

        clear_stats();
        rst_n      = 1'b0;
        start      = 1'b1;
        start_adrs = 2'd2;
        num_vec    = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_outputs");
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(!busy, "start_in_reset_ignored", 64'(busy), 64'(0));

        for (int i = 0; i < 5; i++) begin
            do_run(tbl[i]);
        end

        clear_stats();
        start_run(2'd2, 2'd1);
        wait_xfers(5);
        start      = 1'b1;
        start_adrs = 2'd0;
        num_vec    = 2'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk(adrs == 2'd2, "restart_ignored", 64'(adrs), 64'(2));
        wait_done();
        check_run(2'd1, 34);

        clear_stats();
        start_run(2'd0, 2'd1);
        wait_xfers(NCH + 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("midrun_reset_outputs");
        sbq.delete();
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk(n_done == 0, "no_done_after_reset", 64'(n_done), 64'(0));
        chk(!busy, "idle_after_reset", 64'(busy), 64'(0));
        do_run(tbl[1]);
        do_run('{sa: 2'd0, nv: 2'd1, rnd: 1'b0, exp_last: 34});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
